multicycle_controller: RTL and testbench

Multi-cycle sequencer for the shared RISC-V datapath: steps each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK, one state per cycle or more. In each state it drives the same control strobe set the datapath already consumes (ALU op/src, register write, memory read/write, mem-to-reg, branch). It also drives PC/IR write enables and the shared-memory address select. It stretches memory states on a ready handshake, traps on illegal opcodes or memory timeouts, and counts retired instructions.

---
 rtl/multicycle_controller.sv | 160 ++++++++++++++++
 tb/tb_multicycle_controller.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer for the shared RISC-V datapath.
// Drives datapath strobes, PC/IR enables, memory stretch/timeout traps and a retired counter.
package multicycle_controller_pkg;
  typedef logic [6:0] opcode_t;
  localparam opcode_t OP_LOAD   = 7'b0000011;
  localparam opcode_t OP_STORE  = 7'b0100011;
  localparam opcode_t OP_ARITH  = 7'b0110011;
  localparam opcode_t OP_BRANCH = 7'b1100011;
endpackage

module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  opcode_t          opcode,
  input  logic             mem_ready,
  output logic             pc_w,
  output logic             ir_w,
  output logic             ctrl_i_or_d,
  output logic [1:0]       ctrl_ALU_op,
  output logic             ctrl_ALU_src,
  output logic             ctrl_reg_w,
  output logic             ctrl_mem_r,
  output logic             ctrl_mem_w,
  output logic             ctrl_mem_to_reg,
  output logic             ctrl_branch,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired,
  output logic             fault,
  output logic [1:0]       fault_code
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_START, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_TRAP
  } state_t;

  state_t            state_q, state_d;
  opcode_t           op_q;
  logic [WAIT_W-1:0] wait_q;
  logic [1:0]        trap_code;

  // State register plus opcode latch, wait counter, sticky fault and retire counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_START;
      op_q       <= '0;
      wait_q     <= '0;
      fault      <= 1'b0;
      fault_code <= 2'b00;
      retired    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= opcode;
      if (state_d != state_q)
        wait_q <= '0;
      else if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready)
        wait_q <= wait_q + WAIT_W'(1);
      if (state_d == S_TRAP && state_q != S_TRAP) begin
        fault      <= 1'b1;
        fault_code <= trap_code;
      end
      if (instr_done) retired <= retired + CNT_W'(1);
    end
  end

  // Next state and strobe decode from current state and latched opcode
  always_comb begin
    state_d         = state_q;
    trap_code       = 2'b00;
    pc_w            = 1'b0;
    ir_w            = 1'b0;
    ctrl_i_or_d     = 1'b0;
    ctrl_ALU_op     = 2'b00;
    ctrl_ALU_src    = 1'b0;
    ctrl_reg_w      = 1'b0;
    ctrl_mem_r      = 1'b0;
    ctrl_mem_w      = 1'b0;
    ctrl_mem_to_reg = 1'b0;
    ctrl_branch     = 1'b0;
    instr_done      = 1'b0;
    case (state_q)
      S_START: state_d = S_FETCH;
      S_FETCH: begin
        ctrl_mem_r = 1'b1;
        if (mem_ready) begin
          ir_w    = 1'b1;
          pc_w    = 1'b1;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d   = S_TRAP;
          trap_code = 2'b10;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE, OP_ARITH, OP_BRANCH: state_d = S_EXECUTE;
          default: begin
            state_d   = S_TRAP;
            trap_code = 2'b01;
          end
        endcase
      end
      S_EXECUTE: begin
        case (op_q)
          OP_LOAD, OP_STORE: begin
            ctrl_ALU_src = 1'b1;
            state_d      = S_MEM;
          end
          OP_ARITH: begin
            ctrl_ALU_op = 2'b10;
            state_d     = S_WRITEBACK;
          end
          OP_BRANCH: begin
            ctrl_ALU_op = 2'b01;
            ctrl_branch = 1'b1;
            instr_done  = 1'b1;
            state_d     = S_FETCH;
          end
          default: begin
            state_d   = S_TRAP;
            trap_code = 2'b01;
          end
        endcase
      end
      S_MEM: begin
        ctrl_i_or_d  = 1'b1;
        ctrl_ALU_src = 1'b1;
        ctrl_mem_r   = (op_q == OP_LOAD);
        ctrl_mem_w   = (op_q == OP_STORE);
        if (mem_ready) begin
          if (op_q == OP_STORE) begin
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end else begin
            state_d = S_WRITEBACK;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d   = S_TRAP;
          trap_code = 2'b11;
        end
      end
      S_WRITEBACK: begin
        ctrl_reg_w      = 1'b1;
        ctrl_mem_to_reg = (op_q == OP_LOAD);
        instr_done      = 1'b1;
        state_d         = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed table-driven bench for multicycle_controller, plus a hand-written async reset sequence.
module tb_multicycle_controller;

  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;
  localparam logic [6:0] AR = 7'b0110011;
  localparam logic [6:0] BR = 7'b1100011;
  localparam logic [6:0] XX = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic        mem_ready;
  logic        pc_w, ir_w, ctrl_i_or_d, ctrl_ALU_src, ctrl_reg_w, ctrl_mem_r, ctrl_mem_w;
  logic        ctrl_mem_to_reg, ctrl_branch, instr_done, fault;
  logic [1:0]  ctrl_ALU_op, fault_code;
  logic [31:0] retired;

  logic        d_pc_w, d_ir_w, d_iod, d_src, d_regw, d_memr, d_memw, d_m2r, d_br, d_done, d_flt;
  logic [1:0]  d_aop, d_fc;
  logic [1:0]  retired2;

  always #5 clk = ~clk;

  multicycle_controller #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_w(pc_w), .ir_w(ir_w), .ctrl_i_or_d(ctrl_i_or_d), .ctrl_ALU_op(ctrl_ALU_op),
    .ctrl_ALU_src(ctrl_ALU_src), .ctrl_reg_w(ctrl_reg_w), .ctrl_mem_r(ctrl_mem_r),
    .ctrl_mem_w(ctrl_mem_w), .ctrl_mem_to_reg(ctrl_mem_to_reg), .ctrl_branch(ctrl_branch),
    .instr_done(instr_done), .retired(retired), .fault(fault), .fault_code(fault_code)
  );

  // Narrow-counter copy exercises retired wrap-around
  multicycle_controller #(.MEM_TIMEOUT(4), .CNT_W(2)) dut_w (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_w(d_pc_w), .ir_w(d_ir_w), .ctrl_i_or_d(d_iod), .ctrl_ALU_op(d_aop),
    .ctrl_ALU_src(d_src), .ctrl_reg_w(d_regw), .ctrl_mem_r(d_memr),
    .ctrl_mem_w(d_memw), .ctrl_mem_to_reg(d_m2r), .ctrl_branch(d_br),
    .instr_done(d_done), .retired(retired2), .fault(d_flt), .fault_code(d_fc)
  );

  typedef struct {
    logic        rst;
    logic        rdy;
    logic [6:0]  op;
    logic [14:0] exp;
    logic [31:0] ret;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic logic [14:0] e(input logic pcw, input logic irw, input logic iod,
                                    input logic [1:0] aop, input logic src, input logic regw,
                                    input logic memr, input logic memw, input logic m2r,
                                    input logic br, input logic done, input logic flt,
                                    input logic [1:0] fc);
    return {pcw, irw, iod, aop, src, regw, memr, memw, m2r, br, done, flt, fc};
  endfunction

  function automatic logic [14:0] outs();
    return {pc_w, ir_w, ctrl_i_or_d, ctrl_ALU_op, ctrl_ALU_src, ctrl_reg_w, ctrl_mem_r,
            ctrl_mem_w, ctrl_mem_to_reg, ctrl_branch, instr_done, fault, fault_code};
  endfunction

  task automatic add(input logic r, input logic rdy, input logic [6:0] op,
                     input logic [14:0] ex, input logic [31:0] ret, input int n = 1);
    vec_t v;
    v.rst = r; v.rdy = rdy; v.op = op; v.exp = ex; v.ret = ret;
    for (int i = 0; i < n; i++) vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  logic [14:0] IDLE, F_W, F_R, EX_LS, EX_AR, EX_BR, M_LD, M_ST, M_STD, WB_LD, WB_AR;
  logic [14:0] T01, T10, T11;

  initial begin
    IDLE  = '0;
    F_W   = e(0,0,0,2'b00,0,0,1,0,0,0,0,0,2'b00);
    F_R   = e(1,1,0,2'b00,0,0,1,0,0,0,0,0,2'b00);
    EX_LS = e(0,0,0,2'b00,1,0,0,0,0,0,0,0,2'b00);
    EX_AR = e(0,0,0,2'b10,0,0,0,0,0,0,0,0,2'b00);
    EX_BR = e(0,0,0,2'b01,0,0,0,0,0,1,1,0,2'b00);
    M_LD  = e(0,0,1,2'b00,1,0,1,0,0,0,0,0,2'b00);
    M_ST  = e(0,0,1,2'b00,1,0,0,1,0,0,0,0,2'b00);
    M_STD = e(0,0,1,2'b00,1,0,0,1,0,0,1,0,2'b00);
    WB_LD = e(0,0,0,2'b00,0,1,0,0,1,0,1,0,2'b00);
    WB_AR = e(0,0,0,2'b00,0,1,0,0,0,0,1,0,2'b00);
    T01   = e(0,0,0,2'b00,0,0,0,0,0,0,0,1,2'b01);
    T10   = e(0,0,0,2'b00,0,0,0,0,0,0,0,1,2'b10);
    T11   = e(0,0,0,2'b00,0,0,0,0,0,0,0,1,2'b11);

    add(1, 0, XX, IDLE, 0);
    add(0, 1, XX, IDLE, 0);
    // ARITH zero-wait; opcode wiggles outside DECODE must be ignored
    add(0, 1, XX, F_R,   0); add(0, 1, AR, IDLE, 0);
    add(0, 1, LD, EX_AR, 0); add(0, 1, LD, WB_AR, 0);
    // LOAD with three MEM wait cycles
    add(0, 1, XX, F_R,   1); add(0, 1, LD, IDLE, 1); add(0, 1, XX, EX_LS, 1);
    add(0, 0, XX, M_LD,  1, 3); add(0, 1, XX, M_LD, 1); add(0, 1, ST, WB_LD, 1);
    // STORE then BRANCH zero-wait
    add(0, 1, XX, F_R,   2); add(0, 1, ST, IDLE, 2); add(0, 1, XX, EX_LS, 2);
    add(0, 1, LD, M_STD, 2);
    add(0, 1, XX, F_R,   3); add(0, 1, BR, IDLE, 3); add(0, 1, XX, EX_BR, 3);
    // Ready arrives on the last allowed FETCH cycle: no trap
    add(0, 0, XX, F_W,   4, 3); add(0, 1, XX, F_R, 4); add(0, 1, AR, IDLE, 4);
    add(0, 1, XX, EX_AR, 4); add(0, 1, XX, WB_AR, 4);
    // FETCH timeout
    add(0, 0, XX, F_W,   5, 4); add(0, 1, XX, T10, 5, 2); add(0, 0, AR, T10, 5);
    add(1, 0, XX, IDLE,  0); add(0, 1, XX, IDLE, 0);
    // Illegal opcode
    add(0, 1, XX, F_R,   0); add(0, 1, XX, IDLE, 0);
    add(0, 1, AR, T01,   0, 2); add(0, 0, LD, T01, 0, 2);
    add(1, 0, XX, IDLE,  0); add(0, 1, XX, IDLE, 0);
    // Data (MEM) timeout on a LOAD
    add(0, 1, XX, F_R,   0); add(0, 1, LD, IDLE, 0); add(0, 0, XX, EX_LS, 0);
    add(0, 0, XX, M_LD,  0, 4); add(0, 1, XX, T11, 0, 2);
    add(1, 0, XX, IDLE,  0); add(0, 1, XX, IDLE, 0);

    rst = 1'b1; mem_ready = 1'b0; opcode = XX;
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      rst = vq[i].rst; mem_ready = vq[i].rdy; opcode = vq[i].op;
      #1;
      check($sformatf("vec%0d_outs", i), 32'(outs()), 32'(vq[i].exp));
      check($sformatf("vec%0d_retired", i), retired, vq[i].ret);
      check($sformatf("vec%0d_retired_wrap", i), 32'(retired2), 32'(vq[i].ret[1:0]));
    end

    // Hand sequence: ARITH, then reset asserted mid-MEM of a STORE between clock edges
    @(negedge clk); mem_ready = 1'b1; opcode = XX; #1; check("hs_fetch_irw", 32'(ir_w), 1);
    @(negedge clk); opcode = AR;
    @(negedge clk); opcode = XX;
    @(negedge clk); #1; check("hs_wb_done", 32'(instr_done), 1);
    @(negedge clk);
    @(negedge clk); opcode = ST;
    @(negedge clk); opcode = XX;
    @(negedge clk); mem_ready = 1'b0; #1;
    check("hs_mem_w_on", 32'(ctrl_mem_w), 1);
    check("hs_retired_before", retired, 1);
    #2 rst = 1'b1; #1;
    check("hs_mem_w_async_drop", 32'(ctrl_mem_w), 0);
    check("hs_iod_async_drop", 32'(ctrl_i_or_d), 0);
    check("hs_retired_cleared", retired, 0);
    @(negedge clk); rst = 1'b0; mem_ready = 1'b1; #1;
    check("hs_start_mem_r", 32'(ctrl_mem_r), 0);
    @(negedge clk); #1;
    check("hs_fetch_after_reset", 32'(outs()), 32'(F_R));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
